// File: rtl/dds_ctrl_pkg.sv
// Shared types and constants for the DDS frequency-sweep controller.
package dds_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_REPEAT = 2'd1;
  localparam logic [1:0] MODE_TRI    = 2'd2;

endpackage

// File: rtl/dds_dwell_timer.sv
// Loadable down-counter; expire is high while the count sits at zero, so a
// load of N gives N+1 cycles from load to the first expire cycle inclusive.
module dds_dwell_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer feeding the DDS core freq_word/phase_word inputs:
// single, sawtooth-repeat and triangle sweeps with clamped stepping and abort.
module dds_sweep_ctrl
  import dds_ctrl_pkg::*;
#(
  parameter int FW      = 16,
  parameter int DWELL_W = 16
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [FW-1:0]      cfg_f_start,
  input  logic [FW-1:0]      cfg_f_stop,
  input  logic [FW-1:0]      cfg_f_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [1:0]         cfg_mode,
  input  logic [FW-1:0]      cfg_phase,
  output logic [FW-1:0]      freq_word,
  output logic [FW-1:0]      phase_word,
  output logic               busy,
  output logic               done,
  output logic               wrap,
  output state_e             state_dbg
);

  // Handshake: start is a one-cycle request honoured only in IDLE while abort
  // is low; abort is level-sensitive, beats start, and forces IDLE from RUN/FIN.

  state_e               state, state_nxt;
  logic [FW-1:0]        sh_start, sh_stop, sh_step;
  logic [DWELL_W-1:0]   sh_dwell;
  logic [1:0]           sh_mode;
  logic                 sweep_up, fwd, fwd_nxt, wrap_nxt;
  logic [FW-1:0]        freq_nxt, target;
  logic                 step_up, degen, accept, tmr_load, tmr_expire;

  // One step from cur toward tgt in FW+1 bits; overshoot or carry/borrow clamps to tgt.
  function automatic logic [FW-1:0] step_toward(input logic [FW-1:0] cur,
                                                input logic [FW-1:0] tgt,
                                                input logic [FW-1:0] stp,
                                                input logic          up);
    logic [FW:0] s;
    if (up) begin
      s = {1'b0, cur} + {1'b0, stp};
      if (s[FW] || (s[FW-1:0] > tgt)) s = {1'b0, tgt};
    end else begin
      s = {1'b0, cur} - {1'b0, stp};
      if (s[FW] || (s[FW-1:0] < tgt)) s = {1'b0, tgt};
    end
    return s[FW-1:0];
  endfunction

  // fwd means heading toward f_stop; the triangle return leg clears it.
  assign target  = fwd ? sh_stop : sh_start;
  assign step_up = fwd ? sweep_up : !sweep_up;
  assign degen   = (sh_start == sh_stop) || (sh_step == '0);

  always_comb begin
    state_nxt = state;
    freq_nxt  = freq_word;
    fwd_nxt   = fwd;
    wrap_nxt  = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
          freq_nxt  = cfg_f_start;
          fwd_nxt   = 1'b1;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (tmr_expire) begin
          if (degen) begin
            state_nxt = ST_FIN;
          end else if (freq_word == target) begin
            if (!fwd) begin
              fwd_nxt  = 1'b1;
              freq_nxt = step_toward(freq_word, sh_stop, sh_step, sweep_up);
            end else if (sh_mode == MODE_REPEAT) begin
              freq_nxt = sh_start;
              wrap_nxt = 1'b1;
            end else if (sh_mode == MODE_TRI) begin
              fwd_nxt  = 1'b0;
              freq_nxt = step_toward(freq_word, sh_start, sh_step, !sweep_up);
              wrap_nxt = (freq_nxt == sh_start);
            end else begin
              state_nxt = ST_FIN;
            end
          end else begin
            freq_nxt = step_toward(freq_word, target, sh_step, step_up);
            wrap_nxt = !fwd && (freq_nxt == sh_start);
          end
        end
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign tmr_load = accept || ((state == ST_RUN) && tmr_expire && (state_nxt == ST_RUN));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      freq_word  <= '0;
      phase_word <= '0;
      wrap       <= 1'b0;
      fwd        <= 1'b1;
      sweep_up   <= 1'b1;
      sh_start   <= '0;
      sh_stop    <= '0;
      sh_step    <= '0;
      sh_dwell   <= '0;
      sh_mode    <= MODE_SINGLE;
    end else begin
      state     <= state_nxt;
      freq_word <= freq_nxt;
      fwd       <= fwd_nxt;
      wrap      <= wrap_nxt;
      if (accept) begin
        sh_start   <= cfg_f_start;
        sh_stop    <= cfg_f_stop;
        sh_step    <= cfg_f_step;
        sh_dwell   <= cfg_dwell;
        sh_mode    <= cfg_mode;
        sweep_up   <= (cfg_f_stop >= cfg_f_start);
        phase_word <= cfg_phase;
      end
    end
  end

  dds_dwell_timer #(.W(DWELL_W)) u_dwell (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .load     (tmr_load),
    .load_val (accept ? cfg_dwell : sh_dwell),
    .expire   (tmr_expire)
  );

  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_FIN);
  assign state_dbg = state;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: directed and random sweeps compared
// cycle by cycle against a word-list model of the sweep.
module tb_dds_sweep_ctrl;
  import dds_ctrl_pkg::*;

  localparam int FW = 16;
  localparam int DW = 16;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [FW-1:0] cfg_f_start = '0, cfg_f_stop = '0, cfg_f_step = '0, cfg_phase = '0;
  logic [DW-1:0] cfg_dwell = '0;
  logic [1:0]    cfg_mode = '0;
  logic [FW-1:0] freq_word, phase_word;
  logic          busy, done, wrap;
  state_e        state_dbg;

  typedef int iq_t[$];
  logic [18:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int exp_freq = 0;
  int exp_phase = 0;

  dds_sweep_ctrl #(.FW(FW), .DWELL_W(DW)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .abort(abort),
    .cfg_f_start(cfg_f_start), .cfg_f_stop(cfg_f_stop), .cfg_f_step(cfg_f_step),
    .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode), .cfg_phase(cfg_phase),
    .freq_word(freq_word), .phase_word(phase_word), .busy(busy), .done(done),
    .wrap(wrap), .state_dbg(state_dbg)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Plain integer stepping: overshooting the target in either direction lands on it.
  function automatic int step_to(int cur, int tgt, int stp, bit up);
    int n;
    if (up) begin
      n = cur + stp;
      if (n > tgt) n = tgt;
    end else begin
      n = cur - stp;
      if (n < tgt) n = tgt;
    end
    return n;
  endfunction

  function automatic iq_t make_leg(int a, int b, int stp);
    iq_t q;
    int w = a;
    bit up = (b >= a);
    q.push_back(w);
    while (w != b) begin
      w = step_to(w, b, stp, up);
      q.push_back(w);
    end
    return q;
  endfunction

  // Expected per-cycle outputs {wrap, done, busy, freq} from the first cycle after start.
  function automatic void build_trace(int fs, int fe, int stp, int dw, int md, int min_len);
    int   words[$];
    bit   wr[$];
    bit   fin;
    iq_t  up, dn;
    exp_q.delete();
    if (fs == fe || stp == 0) begin
      words.push_back(fs);
      wr.push_back(1'b0);
      fin = 1'b1;
    end else begin
      up = make_leg(fs, fe, stp);
      dn = make_leg(fe, fs, stp);
      foreach (up[i]) begin
        words.push_back(up[i]);
        wr.push_back(1'b0);
      end
      fin = !(md == 1 || md == 2);
      if (!fin) begin
        while (words.size() * (dw + 1) < min_len) begin
          if (md == 1) begin
            foreach (up[i]) begin
              words.push_back(up[i]);
              wr.push_back(i == 0);
            end
          end else begin
            for (int i = 1; i < dn.size(); i++) begin
              words.push_back(dn[i]);
              wr.push_back(i == dn.size() - 1);
            end
            for (int i = 1; i < up.size(); i++) begin
              words.push_back(up[i]);
              wr.push_back(1'b0);
            end
          end
        end
      end
    end
    foreach (words[i]) begin
      for (int c = 0; c <= dw; c++)
        exp_q.push_back({(wr[i] && c == 0), 1'b0, 1'b1, 16'(words[i])});
    end
    if (fin) begin
      exp_q.push_back({1'b0, 1'b1, 1'b0, 16'(words[words.size()-1])});
      exp_q.push_back({1'b0, 1'b0, 1'b0, 16'(words[words.size()-1])});
      exp_q.push_back({1'b0, 1'b0, 1'b0, 16'(words[words.size()-1])});
    end
  endfunction

  task automatic randomize_cfg();
    cfg_f_start = 16'($urandom_range(0, 65535));
    cfg_f_stop  = 16'($urandom_range(0, 65535));
    cfg_f_step  = 16'($urandom_range(0, 65535));
    cfg_dwell   = 16'($urandom_range(0, 7));
    cfg_mode    = 2'($urandom_range(0, 3));
    cfg_phase   = 16'($urandom_range(0, 65535));
  endtask

  task automatic check_idle(input string tag);
    check_val(tag, {13'b0, wrap, done, busy, freq_word}, {13'b0, 3'b000, 16'(exp_freq)});
    check_val({tag, "_phase"}, {16'b0, phase_word}, 32'(exp_phase));
  endtask

  task automatic run_sweep(input int fs, input int fe, input int stp, input int dw,
                           input int md, input int ph, input int abort_at);
    logic [18:0] e;
    int k;
    bit aborted;
    build_trace(fs, fe, stp, dw, md, abort_at + 2);
    @(negedge sys_clk);
    cfg_f_start = 16'(fs);
    cfg_f_stop  = 16'(fe);
    cfg_f_step  = 16'(stp);
    cfg_dwell   = 16'(dw);
    cfg_mode    = 2'(md);
    cfg_phase   = 16'(ph);
    start       = 1'b1;
    k = 0;
    aborted = 1'b0;
    while (exp_q.size() > 0) begin
      @(negedge sys_clk);
      e = exp_q.pop_front();
      start = 1'b0;
      abort = 1'b0;
      randomize_cfg();
      check_val("trace", {13'b0, wrap, done, busy, freq_word}, {13'b0, e});
      check_val("phase", {16'b0, phase_word}, 32'(ph));
      exp_freq = int'(e[15:0]);
      if (k == abort_at) begin
        abort = 1'b1;
        exp_q.delete();
        aborted = 1'b1;
      end else if (e[16] && $urandom_range(0, 7) == 0) begin
        start = 1'b1;
      end
      k++;
    end
    exp_phase = ph;
    if (aborted) begin
      repeat (2) begin
        @(negedge sys_clk);
        abort = 1'b0;
        check_idle("abort_idle");
      end
    end
  endtask

  task automatic random_sweep();
    int span, stp, fs, fe, dw, md, ab;
    bit up;
    span = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 16'h600);
    stp  = $urandom_range(0, 4) == 0 ? 0 : $urandom_range(span / 12 + 1, span + 16'h40);
    up   = 1'($urandom_range(0, 1));
    if (up) begin
      fs = $urandom_range(0, 3) == 0 ? 16'hFFFF - span : $urandom_range(0, 16'hFFFF - span);
      fe = fs + span;
    end else begin
      fs = $urandom_range(0, 3) == 0 ? span : $urandom_range(span, 16'hFFFF);
      fe = fs - span;
    end
    dw = $urandom_range(0, 3);
    md = $urandom_range(0, 3);
    if (fs != fe && stp != 0 && (md == 1 || md == 2))
      ab = $urandom_range(5, 120);
    else
      ab = $urandom_range(0, 2) == 0 ? $urandom_range(0, 40) : -1;
    run_sweep(fs, fe, stp, dw, md, $urandom_range(0, 65535), ab);
  endtask

  initial begin
    repeat (2) @(negedge sys_clk);
    check_idle("reset");
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check_idle("post_reset");

    run_sweep(16'h100, 16'h140, 16'h20, 2, 0, 16'h1234, -1);
    run_sweep(16'h10, 16'h35, 16'h10, 1, 0, 16'h0042, -1);
    run_sweep(16'hFFE0, 16'hFFFF, 16'h40, 1, 0, 16'hA5A5, -1);
    run_sweep(16'h0, 16'h30, 16'h10, 0, 2, 16'h0007, 30);
    run_sweep(16'h0, 16'h30, 16'h10, 2, 0, 16'h0300, 7);

    // start together with abort while idle must be dropped
    @(negedge sys_clk);
    randomize_cfg();
    start = 1'b1;
    abort = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    abort = 1'b0;
    check_idle("start_abort");
    @(negedge sys_clk);
    check_idle("start_abort_hold");

    run_sweep(16'h50, 16'h80, 0, 1, 1, 16'h1111, -1);
    run_sweep(16'h77, 16'h77, 5, 0, 2, 16'h2222, -1);
    run_sweep(16'h30, 16'h0, 16'h20, 1, 0, 16'h3333, -1);
    run_sweep(16'h9000, 16'h8F00, 16'h70, 0, 1, 16'h4444, 40);
    run_sweep(16'h20, 16'h90, 16'h30, 1, 3, 16'h5555, -1);
    run_sweep(16'h0010, 16'h0, 16'h30, 0, 2, 16'h6666, 12);

    for (int i = 0; i < 40; i++) random_sweep();

    // asynchronous reset in the middle of a sweep clears outputs without a clock edge
    @(negedge sys_clk);
    cfg_f_start = 16'h100;
    cfg_f_stop  = 16'h140;
    cfg_f_step  = 16'h20;
    cfg_dwell   = 16'd2;
    cfg_mode    = 2'd0;
    cfg_phase   = 16'hBEEF;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    repeat (3) @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    exp_freq = 0;
    exp_phase = 0;
    check_idle("async_reset");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check_idle("after_async_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
